gcd_scheduler: RTL and testbench
================================

GCD_SCHEDULER -- requirements
Module: gcd_scheduler

Interface
REQ-001 Parameter: NUM_REQ, 4, number of requesters (2..8).
REQ-002 Parameter: WIDTH, 40, operand/result width in bits.
REQ-003 Parameter: MAX_CYCLES, 128, engine cycle budget per operation; used only when the timeout feature is compiled in.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: reset_n  input  1  one clock; reset is asynchronous and active-low.
REQ-006 Port: req_valid  input  NUM_REQ  per-requester request valid.
REQ-007 Port: req_ready  output  NUM_REQ  per-requester request accept, at most one bit high per cycle.
REQ-008 Port: req_x  input  NUM_REQ*WIDTH  flattened operand x; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 Port: req_y  input  NUM_REQ*WIDTH  flattened operand y, same packing as req_x.
REQ-010 Port: resp_valid  output  1  response valid.
REQ-011 Port: resp_ready  input  1  response accept.
REQ-012 Port: resp_id  output  clog2(NUM_REQ)  index of the requester being answered.
REQ-013 Port: resp_result  output  WIDTH  gcd(x,y).
REQ-014 Port: resp_err  output  1  operation aborted by timeout.
REQ-015 Port: busy  output  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, CHECK, RUN, RESP.
REQ-017 IDLE: grant = first i with req_valid[i], searching round-robin from rr_ptr; drive req_ready[grant]=1 combinationally in the same cycle; on the handshake, register x, y and the grant index, then go to CHECK.
REQ-018 CHECK (1 cycle): if x==0 or y==0, set result = x|y and go to RESP without starting the engine; otherwise pulse engine start for 1 cycle and go to RUN.
REQ-019 RUN: wait for engine done; capture the engine result, clear resp_err and go to RESP.
REQ-020 RESP: hold resp_valid=1 with stable resp_id/result/err until resp_ready=1; on the handshake set rr_ptr = (id+1) mod NUM_REQ and go to IDLE.
REQ-021 req_ready is 0 in every state except IDLE, so only one operation is in flight.
REQ-022 Minimum latency from request handshake to resp_valid: 2 cycles on the zero-operand bypass; 2 + engine cycles otherwise.
REQ-023 A requester dropping req_valid before its handshake is not served; no request is stored without a handshake.
REQ-024 resp_result is exactly WIDTH bits; gcd(0,0)=0.

Reset
REQ-025 Assertion of reset_n low at any time, including mid-RUN, forces state=IDLE and rr_ptr=0, aborts the engine, and clears all internal registers.
REQ-026 Output values while reset is asserted: req_ready=0, resp_valid=0, resp_id=0, resp_result=0, resp_err=0, busy=0.

Configuration
REQ-027 Macro GCD_SCHED_TIMEOUT_EN: when defined, a RUN cycle counter runs; reaching MAX_CYCLES without done aborts the engine, sets resp_result=0 and resp_err=1, and goes to RESP.
REQ-028 Without GCD_SCHED_TIMEOUT_EN: there is no counter, RUN waits indefinitely, and resp_err is tied to 0.

Structure
REQ-029 A shared package gcd_pkg holds the FSM state encoding, the default WIDTH and the default MAX_CYCLES.
REQ-030 The datapath is one sub-module, gcd_engine: iterative binary GCD with inputs start, abort, x, y and outputs done (1-cycle pulse) and result, non-zero operands only.
REQ-031 gcd_engine has exactly one instance, shared by all requesters.

Verification
REQ-032 Single request, requester 0: x=48, y=18 -> resp_id=0, resp_result=6, resp_err=0.
REQ-033 Zero bypass: x=0, y=7 -> resp_result=7, resp_valid exactly 2 cycles after the handshake, engine start never pulsed.
REQ-034 Fairness: all 4 requesters held valid continuously -> service order 0,1,2,3,0 with no requester served twice in a row.
REQ-035 Backpressure: resp_ready held low for 10 cycles -> resp_valid and outputs stable, req_ready stays 0.
REQ-036 Reset mid-RUN: reset_n pulsed low during gcd(2^39, 3) -> outputs 0, state IDLE, next request gcd(12,8) returns 4.
REQ-037 With GCD_SCHED_TIMEOUT_EN and MAX_CYCLES=4: request gcd(2^39-1, 1) -> resp_err=1, resp_result=0.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD scheduler: FSM state encoding and
// default sizing parameters.
package gcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        RESP  = 2'd3
    } gcd_state_e;

    localparam int GCD_WIDTH_DEF      = 40;
    localparam int GCD_MAX_CYCLES_DEF = 128;

endpackage

// File: rtl/gcd_engine.sv
// Iterative binary GCD datapath. Operands must both be non-zero; the
// caller bypasses the engine for zero operands. done pulses for one cycle
// with result valid in the same cycle and held until the next completion.
module gcd_engine
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int SH_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [SH_W-1:0]  sh_q;
    logic             run_q;

    // One reduction step per cycle: strip common factors of two, strip
    // lone factors of two, otherwise subtract the smaller odd value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q    <= '0;
            b_q    <= '0;
            sh_q   <= '0;
            run_q  <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                run_q <= 1'b0;
            end else if (start) begin
                a_q   <= x;
                b_q   <= y;
                sh_q  <= '0;
                run_q <= 1'b1;
            end else if (run_q) begin
                if (a_q == b_q) begin
                    run_q  <= 1'b0;
                    done   <= 1'b1;
                    result <= a_q << sh_q;
                end else if (!a_q[0] && !b_q[0]) begin
                    a_q  <= a_q >> 1;
                    b_q  <= b_q >> 1;
                    sh_q <= sh_q + SH_W'(1);
                end else if (!a_q[0]) begin
                    a_q <= a_q >> 1;
                end else if (!b_q[0]) begin
                    b_q <= b_q >> 1;
                end else if (a_q > b_q) begin
                    a_q <= a_q - b_q;
                end else begin
                    b_q <= b_q - a_q;
                end
            end
        end
    end

endmodule

// File: rtl/gcd_scheduler.sv
// Round-robin front end that shares one gcd_engine among NUM_REQ
// requesters, one operation in flight at a time.
// Optional feature macro: GCD_SCHED_TIMEOUT_EN (RUN cycle budget of
// MAX_CYCLES; on expiry the engine is aborted and resp_err is raised).
//
//   state | meaning
//   IDLE  | arbitrate, accept one request, latch operands and id
//   CHECK | zero-operand bypass or start the engine
//   RUN   | wait for engine done (or timeout when compiled in)
//   RESP  | hold response until resp_ready, then advance rr pointer
module gcd_scheduler
    import gcd_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = GCD_WIDTH_DEF,
    parameter int MAX_CYCLES = GCD_MAX_CYCLES_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_x,
    input  logic [NUM_REQ*WIDTH-1:0]   req_y,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic [$clog2(NUM_REQ)-1:0] resp_id,
    output logic [WIDTH-1:0]           resp_result,
    output logic                       resp_err,
    output logic                       busy
);

    localparam int ID_W = $clog2(NUM_REQ);

    gcd_state_e       state_q, state_d;
    logic [ID_W-1:0]  rr_q;
    logic [ID_W-1:0]  id_q;
    logic [WIDTH-1:0] x_q, y_q, res_q;
    logic [ID_W-1:0]  grant;
    logic             grant_vld;
    logic             zero_op;
    logic             eng_start, eng_abort, eng_done;
    logic [WIDTH-1:0] eng_res;
    logic             tmo;

    assign zero_op = (x_q == '0) || (y_q == '0);

    // First valid requester at or after rr_q, wrapping around.
    always_comb begin
        int idx_i;
        logic [ID_W-1:0] idx;
        idx_i     = 0;
        idx       = '0;
        grant     = '0;
        grant_vld = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_i = int'(rr_q) + k;
            if (idx_i >= NUM_REQ) idx_i = idx_i - NUM_REQ;
            idx = ID_W'(idx_i);
            if (!grant_vld && req_valid[idx]) begin
                grant_vld = 1'b1;
                grant     = idx;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state, request accept and engine start.
    // req_ready is gated by reset_n because IDLE is also the reset state.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        eng_start = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    req_ready[grant] = reset_n;
                    state_d          = CHECK;
                end
            end
            CHECK: begin
                if (zero_op) begin
                    state_d = RESP;
                end else begin
                    eng_start = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN:     if (eng_done || tmo) state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand/id capture, result capture and round-robin pointer update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_q  <= '0;
            id_q  <= '0;
            x_q   <= '0;
            y_q   <= '0;
            res_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant_vld) begin
                        x_q  <= req_x[grant*WIDTH +: WIDTH];
                        y_q  <= req_y[grant*WIDTH +: WIDTH];
                        id_q <= grant;
                    end
                end
                CHECK: if (zero_op) res_q <= x_q | y_q;
                RUN: begin
                    if (eng_done)  res_q <= eng_res;
                    else if (tmo)  res_q <= '0;
                end
                RESP: begin
                    if (resp_ready)
                        rr_q <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef GCD_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             err_q;

    // Done in the last budgeted cycle still counts as success.
    assign tmo       = (state_q == RUN) && !eng_done && (cnt_q == '0);
    assign eng_abort = tmo;
    assign resp_err  = err_q;

    // RUN budget down-counter, loaded so RUN lasts at most MAX_CYCLES cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == CHECK) begin
                cnt_q <= CNT_W'(MAX_CYCLES - 1);
                err_q <= 1'b0;
            end else if (state_q == RUN) begin
                if (eng_done)           err_q <= 1'b0;
                else if (tmo)           err_q <= 1'b1;
                if (cnt_q != '0)        cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end
`else
    logic unused_max_cycles;

    assign unused_max_cycles = (MAX_CYCLES > 0);
    assign tmo               = 1'b0;
    assign eng_abort         = 1'b0;
    assign resp_err          = 1'b0;
`endif

    assign resp_valid  = (state_q == RESP);
    assign resp_id     = id_q;
    assign resp_result = res_q;
    assign busy        = (state_q != IDLE);

    gcd_engine #(
        .WIDTH (WIDTH)
    ) u_engine (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (eng_start),
        .abort   (eng_abort),
        .x       (x_q),
        .y       (y_q),
        .done    (eng_done),
        .result  (eng_res)
    );

endmodule

// File: tb/tb_gcd_scheduler.sv
// Bench for gcd_scheduler: fixed vectors, random traffic against a
// Euclid/round-robin reference, and hand-written corner sequences.
module tb_gcd_scheduler;

    localparam int N = 4;
    localparam int W = 40;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_x = '0;
    logic [N*W-1:0] req_y = '0;
    logic           resp_valid;
    logic           resp_ready = 1'b0;
    logic [1:0]     resp_id;
    logic [W-1:0]   resp_result;
    logic           resp_err;
    logic           busy;

    always #5 clk = ~clk;

    gcd_scheduler #(.NUM_REQ(N), .WIDTH(W), .MAX_CYCLES(1024)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_result(resp_result),
        .resp_err(resp_err), .busy(busy)
    );

`ifdef GCD_SCHED_TIMEOUT_EN
    logic [N-1:0]   t_req_valid = '0;
    logic [N-1:0]   t_req_ready;
    logic [N*W-1:0] t_req_x = '0;
    logic [N*W-1:0] t_req_y = '0;
    logic           t_resp_valid;
    logic           t_resp_ready = 1'b0;
    logic [1:0]     t_resp_id;
    logic [W-1:0]   t_resp_result;
    logic           t_resp_err;
    logic           t_busy;

    gcd_scheduler #(.NUM_REQ(N), .WIDTH(W), .MAX_CYCLES(4)) t_dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(t_req_valid), .req_ready(t_req_ready),
        .req_x(t_req_x), .req_y(t_req_y),
        .resp_valid(t_resp_valid), .resp_ready(t_resp_ready),
        .resp_id(t_resp_id), .resp_result(t_resp_result),
        .resp_err(t_resp_err), .busy(t_busy)
    );
`endif

    int total = 0;
    int bad   = 0;
    int starts = 0;
    int rr_m  = 0;
    logic [W-1:0] opx [N];
    logic [W-1:0] opy [N];

    typedef struct {
        int           id;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] res;
        bit           bypass;
    } vec_t;
    vec_t tbl [8];

    always @(posedge clk) if (dut.eng_start) starts++;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int exp_grant(input logic [N-1:0] m);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (rr_m + k) % N;
            if (m[i]) return i;
        end
        return 0;
    endfunction

    task automatic pack_ops();
        for (int i = 0; i < N; i++) begin
            req_x[i*W +: W] = opx[i];
            req_y[i*W +: W] = opy[i];
        end
    endtask

    // Called at posedge+1 with the DUT idle. lat counts cycles from the
    // handshake cycle (0) to the first cycle showing resp_valid.
    task automatic do_op(input logic [N-1:0] mask, output int g, output int lat,
                         output logic [1:0] id, output logic [W-1:0] res, output logic err);
        logic [N-1:0] onehot;
        pack_ops();
        req_valid  = mask;
        resp_ready = 1'b0;
        #1;
        g = exp_grant(mask);
        onehot = '0;
        onehot[g] = 1'b1;
        chk("req_ready_grant", 64'(req_ready), 64'(onehot));
        @(posedge clk); #1;
        req_valid = '0;
        lat = 1;
        while (!resp_valid && lat < 3000) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("resp_valid_seen", 64'(resp_valid), 64'd1);
        id  = resp_id;
        res = resp_result;
        err = resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        rr_m = (g + 1) % N;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        rr_m = 0;
        @(posedge clk); #1;
    endtask

    initial begin
        int g, lat, s0, cnt, cyc;
        logic [1:0] id;
        logic [W-1:0] res, c;
        logic err;
        logic [1:0] order [5];
        logic [W-1:0] ores [5];

        tbl[0] = '{0, 40'd48, 40'd18, 40'd6, 1'b0};
        tbl[1] = '{1, 40'd0, 40'd7, 40'd7, 1'b1};
        tbl[2] = '{2, 40'd7, 40'd0, 40'd7, 1'b1};
        tbl[3] = '{3, 40'd0, 40'd0, 40'd0, 1'b1};
        tbl[4] = '{1, 40'd12, 40'd8, 40'd4, 1'b0};
        tbl[5] = '{2, 40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 40'hFF_FFFF_FFFF, 1'b0};
        tbl[6] = '{3, 40'h80_0000_0000, 40'h00_0010_0000, 40'h00_0010_0000, 1'b0};
        tbl[7] = '{0, 40'd1071, 40'd462, 40'd21, 1'b0};

        // Reset values with every requester asking.
        for (int i = 0; i < N; i++) begin opx[i] = 40'd5; opy[i] = 40'd3; end
        pack_ops();
        req_valid = '1;
        #12;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_id", 64'(resp_id), 64'd0);
        chk("rst_resp_result", 64'(resp_result), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        req_valid = '0;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Fixed vectors, one requester at a time.
        for (int t = 0; t < 8; t++) begin
            opx[tbl[t].id] = tbl[t].x;
            opy[tbl[t].id] = tbl[t].y;
            s0 = starts;
            do_op(4'b0001 << tbl[t].id, g, lat, id, res, err);
            chk($sformatf("vec%0d_id", t), 64'(id), 64'(tbl[t].id));
            chk($sformatf("vec%0d_result", t), 64'(res), 64'(tbl[t].res));
            chk($sformatf("vec%0d_err", t), 64'(err), 64'd0);
            if (tbl[t].bypass) begin
                chk($sformatf("vec%0d_latency", t), 64'(lat), 64'd2);
                chk($sformatf("vec%0d_no_start", t), 64'(starts - s0), 64'd0);
            end else begin
                chk($sformatf("vec%0d_one_start", t), 64'(starts - s0), 64'd1);
            end
        end

        // Random traffic with competing requesters.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < N; i++) begin
                c = 40'($urandom_range(1, 5000));
                case ($urandom_range(0, 4))
                    0: begin opx[i] = 40'($urandom_range(0, 300)); opy[i] = 40'($urandom_range(0, 300)); end
                    1: begin opx[i] = 40'({$urandom, $urandom}); opy[i] = 40'({$urandom, $urandom}); end
                    2: begin opx[i] = c * 40'($urandom_range(1, 100000)); opy[i] = c * 40'($urandom_range(1, 100000)); end
                    3: begin opx[i] = 40'd1 << $urandom_range(0, 39); opy[i] = 40'd1 << $urandom_range(0, 39); end
                    default: begin opx[i] = 40'd0; opy[i] = 40'($urandom); end
                endcase
            end
            do_op(4'($urandom_range(1, 15)), g, lat, id, res, err);
            chk("rand_id", 64'(id), 64'(g));
            chk("rand_result", 64'(res), 64'(ref_gcd(opx[g], opy[g])));
            chk("rand_err", 64'(err), 64'd0);
        end

        // Backpressure: response held while others keep asking.
        opx[1] = 40'd1071; opy[1] = 40'd462;
        pack_ops();
        req_valid = 4'b0010;
        @(posedge clk); #1;
        req_valid = 4'b1101;
        cyc = 0;
        while (!resp_valid && cyc < 3000) begin @(posedge clk); #1; cyc++; end
        for (int k = 0; k < 10; k++) begin
            chk("bp_resp_valid", 64'(resp_valid), 64'd1);
            chk("bp_resp_id", 64'(resp_id), 64'd1);
            chk("bp_resp_result", 64'(resp_result), 64'd21);
            chk("bp_resp_err", 64'(resp_err), 64'd0);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        req_valid = '0;
        rr_m = 2;
        chk("bp_after_busy", 64'(busy), 64'd0);

        // Reset in the middle of a long engine run.
        opx[1] = 40'h80_0000_0000; opy[1] = 40'd3;
        pack_ops();
        req_valid = 4'b0010;
        @(posedge clk); #1;
        req_valid = '0;
        repeat (6) @(posedge clk);
        #1;
        chk("mid_run_busy", 64'(busy), 64'd1);
        #2;
        req_valid = '1;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("mid_rst_resp_id", 64'(resp_id), 64'd0);
        chk("mid_rst_resp_result", 64'(resp_result), 64'd0);
        chk("mid_rst_resp_err", 64'(resp_err), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_hold_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        req_valid = '0;
        rr_m = 0;
        #1;
        chk("post_rst_busy", 64'(busy), 64'd0);
        req_valid = '1;
        #1;
        chk("post_rst_rr_ptr0", 64'(req_ready), 64'd1);
        req_valid = '0;
        @(posedge clk); #1;
        cnt = 0;
        for (int k = 0; k < 60; k++) begin
            if (resp_valid || busy) cnt++;
            @(posedge clk); #1;
        end
        chk("post_rst_quiet", 64'(cnt), 64'd0);
        opx[2] = 40'd12; opy[2] = 40'd8;
        do_op(4'b0100, g, lat, id, res, err);
        chk("post_rst_id", 64'(id), 64'd2);
        chk("post_rst_result", 64'(res), 64'd4);

        // Fairness with all requesters held valid.
        do_reset();
        for (int i = 0; i < N; i++) begin opx[i] = 40'(12 * (i + 1)); opy[i] = 40'd8; end
        pack_ops();
        req_valid = '1;
        resp_ready = 1'b1;
        cnt = 0;
        cyc = 0;
        while (cnt < 5 && cyc < 3000) begin
            @(negedge clk);
            if (resp_valid) begin
                order[cnt] = resp_id;
                ores[cnt]  = resp_result;
                cnt++;
            end
            cyc++;
        end
        req_valid = '0;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        rr_m = 1;
        chk("fair_count", 64'(cnt), 64'd5);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("fair_order%0d", k), 64'(order[k]), 64'(k % N));
            chk($sformatf("fair_result%0d", k), 64'(ores[k]), 64'(ref_gcd(opx[k % N], opy[k % N])));
        end

`ifdef GCD_SCHED_TIMEOUT_EN
        // Timeout instance with a 4-cycle budget.
        t_req_x[0 +: W] = 40'h7F_FFFF_FFFF;
        t_req_y[0 +: W] = 40'd1;
        t_req_valid = 4'b0001;
        @(posedge clk); #1;
        t_req_valid = '0;
        cyc = 0;
        while (!t_resp_valid && cyc < 3000) begin @(posedge clk); #1; cyc++; end
        chk("tmo_resp_valid", 64'(t_resp_valid), 64'd1);
        chk("tmo_resp_id", 64'(t_resp_id), 64'd0);
        chk("tmo_resp_err", 64'(t_resp_err), 64'd1);
        chk("tmo_resp_result", 64'(t_resp_result), 64'd0);
        t_resp_ready = 1'b1;
        @(posedge clk); #1;
        t_resp_ready = 1'b0;
        chk("tmo_idle", 64'(t_busy), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
